// File: rtl/rbz_reg_commit_sched.sv
// Two-source register write scheduler: arbitrates grouped beats into one FIFO and
// commits whole groups during vertical blanking so multi-word updates never tear.
module rbz_reg_commit_sched #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_vblank,
  input  logic                      i_vec_valid,
  input  logic                      i_vec_last,
  input  logic [ADDR_W-1:0]         i_vec_addr,
  input  logic [DATA_W-1:0]         i_vec_data,
  output logic                      o_vec_ready,
  input  logic                      i_reg_valid,
  input  logic                      i_reg_last,
  input  logic [ADDR_W-1:0]         i_reg_addr,
  input  logic [DATA_W-1:0]         i_reg_data,
  output logic                      o_reg_ready,
  output logic                      o_wr_en,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic [DATA_W-1:0]         o_wr_data,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic                      o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d, groups_q, groups_d;
  logic              lock_valid_q, lock_valid_d, lock_src_q, lock_src_d;
  logic              rr_q, rr_d;
  logic              overflow_q, overflow_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  state_t            state_q, state_d;

  logic   gnt_vec, gnt_reg, not_full, push_vec, push_reg, push, pop;
  logic   push_last, pop_last, flush;
  entry_t push_entry, head;

  // lock_src / rr: 0 = vec, 1 = reg
  always_comb begin
    gnt_vec = 1'b0;
    gnt_reg = 1'b0;
    if (lock_valid_q) begin
      gnt_vec = ~lock_src_q;
      gnt_reg = lock_src_q;
    end else if (i_vec_valid && i_reg_valid) begin
      gnt_vec = ~rr_q;
      gnt_reg = rr_q;
    end else begin
      gnt_vec = i_vec_valid;
      gnt_reg = i_reg_valid;
    end
  end

  assign not_full    = level_q != LW'(DEPTH);
  assign o_vec_ready = gnt_vec & not_full;
  assign o_reg_ready = gnt_reg & not_full;
  assign push_vec    = i_vec_valid & o_vec_ready;
  assign push_reg    = i_reg_valid & o_reg_ready;
  assign push        = push_vec | push_reg;
  assign push_entry  = push_reg ? {i_reg_last, i_reg_addr, i_reg_data}
                                : {i_vec_last, i_vec_addr, i_vec_data};
  assign head        = mem_q[rd_ptr_q];
  assign pop         = state_q == S_DRAIN;
  assign push_last   = push & push_entry.last;
  assign pop_last    = pop & head.last;
  // A full FIFO with no complete group can never drain: drop it.
  assign flush       = ~not_full && (groups_q == '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_src_d   = lock_src_q;
    rr_d         = rr_q;
    overflow_d   = overflow_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = pop;
    level_d      = level_q + LW'(push) - LW'(pop);
    groups_d     = groups_q + LW'(push_last) - LW'(pop_last);
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PW'(1);
      lock_valid_d = ~push_entry.last;
      lock_src_d   = push_reg;
      rr_d         = push_vec;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      lock_valid_d = 1'b0;
      overflow_d   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_vblank && groups_q != '0) state_d = S_DRAIN;
      S_DRAIN: if (pop_last && !(i_vblank && groups_d != '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      groups_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_src_q   <= 1'b0;
      rr_q         <= 1'b0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      state_q      <= S_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      groups_q     <= groups_d;
      lock_valid_q <= lock_valid_d;
      lock_src_q   <= lock_src_d;
      rr_q         <= rr_d;
      overflow_q   <= overflow_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      state_q      <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_level    = level_q;
  assign o_overflow = overflow_q;
endmodule

// File: tb/tb_rbz_reg_commit_sched.sv
// Bench for rbz_reg_commit_sched: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_rbz_reg_commit_sched;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;

  typedef struct {
    bit        last;
    bit [3:0]  addr;
    bit [23:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_vblank = 1'b0;
  logic i_vec_valid = 1'b0, i_vec_last = 1'b0;
  logic [ADDR_W-1:0] i_vec_addr = '0;
  logic [DATA_W-1:0] i_vec_data = '0;
  logic i_reg_valid = 1'b0, i_reg_last = 1'b0;
  logic [ADDR_W-1:0] i_reg_addr = '0;
  logic [DATA_W-1:0] i_reg_data = '0;
  logic o_vec_ready, o_reg_ready, o_wr_en, o_overflow;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [$clog2(DEPTH):0] o_level;

  rbz_reg_commit_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_vblank(i_vblank),
    .i_vec_valid(i_vec_valid), .i_vec_last(i_vec_last), .i_vec_addr(i_vec_addr),
    .i_vec_data(i_vec_data), .o_vec_ready(o_vec_ready),
    .i_reg_valid(i_reg_valid), .i_reg_last(i_reg_last), .i_reg_addr(i_reg_addr),
    .i_reg_data(i_reg_data), .o_reg_ready(o_reg_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_level(o_level), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model state
  beat_t m_q[$];
  bit    m_lock, m_lsrc, m_pref_reg, m_drain, m_ovf, m_wen;
  bit [3:0]  m_waddr;
  bit [23:0] m_wdata;

  beat_t vec_src[$], reg_src[$];
  int    acc_log[$];          // 0 = vec, 1 = reg
  int    obs_addr[$];
  int    obs_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_groups();
    int n = 0;
    foreach (m_q[i]) if (m_q[i].last) n++;
    return n;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_lock = 0; m_lsrc = 0; m_pref_reg = 0; m_drain = 0; m_ovf = 0; m_wen = 0;
    m_waddr = 0; m_wdata = 0;
  endtask

  task automatic push_grp(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.last = (k == len - 1);
      b.addr = 4'($urandom);
      b.data = 24'($urandom);
      if (src == 0) vec_src.push_back(b); else reg_src.push_back(b);
    end
  endtask

  function automatic beat_t mk(input int a, input int d, input bit l);
    beat_t b;
    b.addr = 4'(a); b.data = 24'(d); b.last = l;
    return b;
  endfunction

  // Entered at posedge+1; drives one cycle, checks before the edge, advances the model.
  task automatic step(input bit gate_v, input bit gate_r, input bit vb);
    bit vv, rv, gv, gr, full, ev, er, acc_v, acc_r, popped_last;
    int lvl, grp;
    beat_t e;
    vv = gate_v && vec_src.size() > 0;
    rv = gate_r && reg_src.size() > 0;
    i_vblank    = vb;
    i_vec_valid = vv;
    i_vec_last  = vv ? vec_src[0].last : 1'b0;
    i_vec_addr  = vv ? vec_src[0].addr : '0;
    i_vec_data  = vv ? vec_src[0].data : '0;
    i_reg_valid = rv;
    i_reg_last  = rv ? reg_src[0].last : 1'b0;
    i_reg_addr  = rv ? reg_src[0].addr : '0;
    i_reg_data  = rv ? reg_src[0].data : '0;
    #3;
    lvl  = m_q.size();
    grp  = m_groups();
    full = (lvl == DEPTH);
    if (m_lock)        begin gv = !m_lsrc;     gr = m_lsrc;     end
    else if (vv && rv) begin gv = !m_pref_reg; gr = m_pref_reg; end
    else               begin gv = vv;          gr = rv;         end
    ev = gv && !full;
    er = gr && !full;
    chk("vec_ready", o_vec_ready, ev);
    chk("reg_ready", o_reg_ready, er);
    chk("level", o_level, lvl);
    chk("wr_en", o_wr_en, m_wen);
    chk("overflow", o_overflow, m_ovf);
    if (m_wen) begin
      chk("wr_addr", o_wr_addr, m_waddr);
      chk("wr_data", o_wr_data, m_wdata);
    end
    if (o_wr_en === 1'b1) begin
      obs_addr.push_back(int'(o_wr_addr));
      obs_data.push_back(int'(o_wr_data));
    end
    acc_v = vv && ev;
    acc_r = rv && er;
    @(posedge clk);
    popped_last = 0;
    m_wen = 0;
    if (m_drain) begin
      e = m_q.pop_front();
      m_wen = 1; m_waddr = e.addr; m_wdata = e.data;
      popped_last = e.last;
    end
    if (acc_v || acc_r) begin
      e = acc_r ? reg_src.pop_front() : vec_src.pop_front();
      m_q.push_back(e);
      m_lock = !e.last;
      m_lsrc = acc_r;
      m_pref_reg = acc_v;
      acc_log.push_back(acc_r ? 1 : 0);
    end
    if (full && grp == 0) begin
      m_q.delete();
      m_lock = 0;
      m_ovf  = 1;
    end
    if (!m_drain) m_drain = vb && grp > 0;
    else if (popped_last) m_drain = vb && m_groups() > 0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_vec_valid = 0; i_reg_valid = 0; i_vblank = 0;
    vec_src.delete(); reg_src.delete();
    acc_log.delete(); obs_addr.delete(); obs_data.delete();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_level", o_level, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_vec_ready", o_vec_ready, 0);

    // basic two-beat group committed once vblank rises
    vec_src.push_back(mk(1, 'h100, 0));
    vec_src.push_back(mk(2, 'h200, 1));
    repeat (5) step(1, 1, 0);
    chk("A_no_commit", obs_addr.size(), 0);
    repeat (6) step(1, 1, 1);
    chk("A_count", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("A_addr0", obs_addr[0], 1);
      chk("A_addr1", obs_addr[1], 2);
      chk("A_data0", obs_data[0], 'h100);
      chk("A_data1", obs_data[1], 'h200);
    end
    chk("A_level", o_level, 0);

    // round robin between two always-valid sources
    do_reset();
    for (int k = 0; k < 4; k++) begin
      vec_src.push_back(mk(3, 'h30 + k, 1));
      reg_src.push_back(mk(4, 'h40 + k, 1));
    end
    repeat (14) step(1, 1, 1);
    chk("B_acc_n", acc_log.size(), 8);
    chk("B_com_n", obs_addr.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < acc_log.size())  chk("B_acc_src", acc_log[k], k % 2);
      if (k < obs_addr.size()) chk("B_com_addr", obs_addr[k], (k % 2) ? 4 : 3);
    end

    // lock holds reg off until vec's group is closed
    do_reset();
    vec_src.push_back(mk(5, 'h50, 0));
    step(1, 1, 0);
    reg_src.push_back(mk(6, 'h60, 1));
    repeat (3) step(1, 1, 0);
    chk("C_reg_blocked", acc_log.size(), 1);
    vec_src.push_back(mk(7, 'h70, 1));
    repeat (3) step(1, 1, 0);
    repeat (6) step(1, 1, 1);
    chk("C_com_n", obs_addr.size(), 3);
    if (obs_addr.size() == 3) begin
      chk("C_com0", obs_addr[0], 5);
      chk("C_com1", obs_addr[1], 7);
      chk("C_com2", obs_addr[2], 6);
    end

    // vblank falls mid-group: group completes, next group waits
    do_reset();
    vec_src.push_back(mk(1, 'h11, 0));
    vec_src.push_back(mk(2, 'h22, 0));
    vec_src.push_back(mk(3, 'h33, 1));
    vec_src.push_back(mk(4, 'h44, 1));
    repeat (6) step(1, 1, 0);
    repeat (2) step(1, 1, 1);
    repeat (8) step(1, 1, 0);
    chk("D_first_grp", obs_addr.size(), 3);
    repeat (6) step(1, 1, 1);
    chk("D_second_grp", obs_addr.size(), 4);
    if (obs_addr.size() == 4) chk("D_last_addr", obs_addr[3], 4);

    // oversize group fills the FIFO and is flushed
    do_reset();
    for (int k = 0; k < DEPTH; k++) vec_src.push_back(mk(k, k, 0));
    repeat (DEPTH) step(1, 1, 1);
    chk("E_full", o_level, DEPTH);
    step(1, 1, 1);
    chk("E_flush_level", o_level, 0);
    chk("E_ovf", o_overflow, 1);
    repeat (5) step(1, 1, 1);
    chk("E_ovf_sticky", o_overflow, 1);
    chk("E_no_commit", obs_addr.size(), 0);
    do_reset();
    chk("E_ovf_cleared", o_overflow, 0);

    // asynchronous reset in the middle of a drain
    for (int k = 0; k < 4; k++) vec_src.push_back(mk(8 + k, 'h80 + k, 1));
    repeat (5) step(1, 1, 0);
    repeat (3) step(1, 1, 1);
    #2;
    chk("F_pre_wen", o_wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("F_async_wen", o_wr_en, 0);
    chk("F_async_level", o_level, 0);
    do_reset();
    repeat (6) step(1, 1, 1);
    chk("F_no_commit", obs_addr.size(), 0);

    // random traffic
    do_reset();
    begin
      bit vb = 0;
      for (int c = 0; c < 600; c++) begin
        if (c % 17 == 0) vb = ($urandom_range(0, 2) != 0);
        if (vec_src.size() == 0 && $urandom_range(0, 1) == 1)
          push_grp(0, ($urandom_range(0, 19) == 0) ? 10 : $urandom_range(1, 4));
        if (reg_src.size() == 0 && $urandom_range(0, 1) == 1)
          push_grp(1, ($urandom_range(0, 19) == 0) ? 10 : $urandom_range(1, 4));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, vb);
      end
      vec_src.delete(); reg_src.delete();
      repeat (20) step(1, 1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
